// File: rtl/pixel_unpacker.sv
// Unpacks 32-bit words (four 8-bit pixels, LSB first) from a small FIFO into one pixel per clock,
// with bank/address generation for a two-bank frame store and a sticky end-of-frame flag.
module pixel_unpacker #(
   parameter int unsigned TOTAL_PIX  = 153600,
   parameter int unsigned BANK_PIX   = 76800,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_word,
   output logic        out_enable,
   output logic [7:0]  out_pixel,
   output logic        out_bank,
   output logic [16:0] out_addr,
   output logic [17:0] pix_count,
   output logic        done
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
   localparam logic [17:0]   BANK_L   = 18'(BANK_PIX);
   localparam logic [17:0]   LAST_L   = 18'(TOTAL_PIX - 1);

   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [1:0]    idx_q, idx_d;
   logic          en_q, en_d;
   logic [7:0]    pix_q, pix_d;
   logic          bank_q, bank_d;
   logic [16:0]   addr_q, addr_d;
   logic [17:0]   cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          push, emit, pop;
   logic [31:0]   head;

   always_comb begin
      in_ready = (level_q != DEPTH_L) && !done_q;
      push     = in_valid && in_ready;
      emit     = (level_q != '0) && !done_q;
      pop      = emit && (idx_q == 2'd3);
      head     = mem_q[rptr_q];

      wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      en_d   = emit;
      idx_d  = idx_q;
      pix_d  = pix_q;
      bank_d = bank_q;
      addr_d = addr_q;
      cnt_d  = cnt_q;
      done_d = done_q;
      if (emit) begin
         idx_d = idx_q + 2'd1;
         pix_d = head[{idx_q, 3'b000} +: 8];
         // Address derives from the count of the pixel being emitted, so bank/addr stay consistent with pix_count.
         if (cnt_q >= BANK_L) begin
            bank_d = 1'b1;
            addr_d = 17'(cnt_q - BANK_L);
         end else begin
            bank_d = 1'b0;
            addr_d = 17'(cnt_q);
         end
         cnt_d  = cnt_q + 18'd1;
         done_d = (cnt_q == LAST_L);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= in_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         idx_q   <= '0;
         en_q    <= 1'b0;
         pix_q   <= '0;
         bank_q  <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         idx_q   <= idx_d;
         en_q    <= en_d;
         pix_q   <= pix_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign out_enable = en_q;
   assign out_pixel  = pix_q;
   assign out_bank   = bank_q;
   assign out_addr   = addr_q;
   assign pix_count  = cnt_q;
   assign done       = done_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Randomized bench for pixel_unpacker: byte-queue reference model checked every cycle,
// plus directed literal checks for reset, single word, bank crossing and frame completion.
module tb_pixel_unpacker;

   localparam int unsigned TP = 1200;
   localparam int unsigned BP = 600;
   localparam int unsigned FD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_word = '0;
   logic        out_enable;
   logic [7:0]  out_pixel;
   logic        out_bank;
   logic [16:0] out_addr;
   logic [17:0] pix_count;
   logic        done;

   always #5 clk = ~clk;

   pixel_unpacker #(.TOTAL_PIX(TP), .BANK_PIX(BP), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .out_enable(out_enable), .out_pixel(out_pixel), .out_bank(out_bank),
      .out_addr(out_addr), .pix_count(pix_count), .done(done)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending pixels as a byte queue; FIFO occupancy in words is ceil(bytes/4).
   logic [7:0]  q[$];
   bit          e_en, e_bank, e_done;
   logic [7:0]  e_pix;
   int unsigned e_addr, e_cnt;

   function automatic bit model_ready();
      return (((q.size() + 3) / 4) < FD) && !e_done;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         e_en = 0; e_bank = 0; e_done = 0; e_pix = '0; e_addr = 0; e_cnt = 0;
      end else begin
         bit acc;
         acc = in_valid && model_ready();
         if (q.size() > 0 && !e_done) begin
            e_en   = 1;
            e_pix  = q.pop_front();
            e_bank = (e_cnt >= BP);
            e_addr = e_bank ? e_cnt - BP : e_cnt;
            e_cnt++;
            if (e_cnt == TP) e_done = 1;
         end else begin
            e_en = 0;
         end
         if (acc) for (int i = 0; i < 4; i++) q.push_back(in_word[8*i +: 8]);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", in_ready, model_ready());
         chk("out_enable", out_enable, e_en);
         chk("out_pixel", out_pixel, e_pix);
         chk("out_bank", out_bank, e_bank);
         chk("out_addr", out_addr, e_addr);
         chk("pix_count", pix_count, e_cnt);
         chk("done", done, e_done);
         if (e_en && e_cnt == BP) begin
            chk("last_bank0_bank", out_bank, 0);
            chk("last_bank0_addr", out_addr, BP - 1);
         end
         if (e_en && e_cnt == BP + 1) begin
            chk("first_bank1_bank", out_bank, 1);
            chk("first_bank1_addr", out_addr, 0);
         end
         if (e_en && e_done) begin
            chk("last_pix_bank", out_bank, 1);
            chk("last_pix_addr", out_addr, TP - BP - 1);
            chk("last_pix_done", done, 1);
         end
      end
   end

   task automatic send_word_check(input logic [31:0] w);
      @(posedge clk); #1;
      in_word = w; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         chk("sw_enable", out_enable, 1);
         chk("sw_pixel", out_pixel, w[8*i +: 8]);
         chk("sw_bank", out_bank, 0);
         chk("sw_addr", out_addr, i);
      end
      chk("sw_count", pix_count, 4);
      @(negedge clk);
      chk("sw_idle", out_enable, 0);
   endtask

   task automatic stream(input int unsigned target, input int unsigned prob, input int unsigned max_cyc,
                         output bit reached, output int unsigned stalls);
      bit hs;
      reached = 0; stalls = 0;
      for (int c = 0; c < max_cyc && !reached; c++) begin
         @(negedge clk);
         hs = in_valid && in_ready;
         if (in_valid && !in_ready) stalls++;
         @(posedge clk); #1;
         if (hs || !in_valid) in_word = $urandom;
         in_valid = ($urandom_range(99) < prob);
         if (e_cnt >= target || e_done) reached = 1;
      end
   endtask

   task automatic mid_reset();
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst_enable", out_enable, 0);
      chk("rst_pixel", out_pixel, 0);
      chk("rst_bank", out_bank, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_count", pix_count, 0);
      chk("rst_done", done, 0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", in_ready, 1);
   endtask

   initial begin
      bit          r;
      int unsigned st;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("init_ready", in_ready, 1);

      send_word_check(32'h44332211);

      in_valid = 1'b1;
      stream(300, 90, 4000, r, st);
      if (!r) begin checks++; errors++; $display("FAIL timeout_midframe: pixels %0d expected 300", e_cnt); end
      mid_reset();
      send_word_check($urandom);

      mid_reset();
      in_valid = 1'b1;
      stream(TP, 100, 64, r, st);
      chk("bp_stalls_seen", st > 32, 1);
      stream(TP, 75, 8000, r, st);
      if (!r) begin checks++; errors++; $display("FAIL timeout_frame: pixels %0d expected %0d", e_cnt, TP); end

      in_valid = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("end_done", done, 1);
      chk("end_count", pix_count, TP);
      chk("end_ready", in_ready, 0);
      chk("end_enable", out_enable, 0);
      chk("end_bank", out_bank, 1);
      chk("end_addr", out_addr, TP - BP - 1);
      in_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
